// File: rtl/pbc_pkg.sv
// Shared types and constants for the parity bit checker (pbc) front end.
package pbc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int NUM_DATA_BITS    = 4;
  localparam int DEF_CLKS_PER_BIT = 16;

  // Parity bit that makes the 4 data bits plus parity even.
  function automatic logic even_parity(input logic [NUM_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pbc_serial_rx_if.sv
// Serial line in, parallel parity word out, between pbc_serial_rx and pbc.
interface pbc_serial_rx_if;
  import pbc_pkg::*;

  // frame_valid is a one-cycle strobe with no ready: the consumer must take
  // a,b,c,d,p,frame_err in the strobe cycle or later (they hold until the next
  // frame); there is no backpressure toward the serial line.
  logic      rxd;
  logic      a;
  logic      b;
  logic      c;
  logic      d;
  logic      p;
  logic      frame_valid;
  logic      frame_err;
  logic      busy;
  rx_state_e state;

  modport master (
    input  rxd,
    output a, b, c, d, p, frame_valid, frame_err, busy, state
  );

  modport slave (
    output rxd,
    input  a, b, c, d, p, frame_valid, frame_err, busy, state
  );

endinterface

// File: rtl/pbc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module pbc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pbc_serial_rx.sv
// Serial frame receiver: start, 4 data, parity, stop -> registered a,b,c,d,p.
module pbc_serial_rx
  import pbc_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = 8
) (
  input logic              clk,
  input logic              rst_n,
  pbc_serial_rx_if.master  rx
);

  localparam int IDX_W = $clog2(NUM_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DATA_BITS - 1);

  logic rxd_s;
  logic rxd_prev;

  rx_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           bit_idx_q, bit_idx_d;
  logic [NUM_DATA_BITS-1:0]   shift_q, shift_d;
  logic                       p_shadow_q, p_shadow_d;
  logic [NUM_DATA_BITS-1:0]   data_q, data_d;
  logic                       p_q, p_d;
  logic                       err_q, err_d;
  logic                       valid_q, valid_d;

  // Reset value 1 keeps the idle line from looking like a start edge.
  pbc_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx.rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      p_shadow_q <= 1'b0;
      data_q     <= '0;
      p_q        <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      rxd_prev   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      p_shadow_q <= p_shadow_d;
      data_q     <= data_d;
      p_q        <= p_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      rxd_prev   <= rxd_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    p_shadow_d = p_shadow_q;
    data_d     = data_q;
    p_d        = p_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxd_prev && !rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rxd_s;
          bit_idx_d          = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d      = '0;
          p_shadow_d = rxd_s;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // Outputs move only here, so pbc never sees a partial word.
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          data_d  = shift_q;
          p_d     = p_shadow_q;
          err_d   = ~rxd_s;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx.a           = data_q[0];
  assign rx.b           = data_q[1];
  assign rx.c           = data_q[2];
  assign rx.d           = data_q[3];
  assign rx.p           = p_q;
  assign rx.frame_err   = err_q;
  assign rx.frame_valid = valid_q;
  assign rx.busy        = (state_q != IDLE);
  assign rx.state       = state_q;

endmodule
